// File: rtl/fft_pkg.sv
// fft_pkg: bin count, bin-index width and scheduler state encoding shared by the output scheduler
package fft_pkg;
  localparam int N_BINS = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running 0..DIV-1 slot divider producing a one-cycle tick enable at DIV-1
module tick_gen #(
  parameter int DIV = 25
) (
  input  logic fastclk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  // counter held at zero while cleared, otherwise wraps after DIV-1
  always_ff @(posedge fastclk)
    if (rst || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fft_out_scheduler.sv
// fft_out_scheduler: buffers one 8-bin frame and presents its bins one per slot tick over a valid/ready port
module fft_out_scheduler
  import fft_pkg::*;
#(
  parameter int W = 16,
  parameter int DIV = 25
) (
  input  logic                fastclk,
  input  logic                rst,
  input  logic [N_BINS*W-1:0] frame_re,
  input  logic [N_BINS*W-1:0] frame_im,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic [W-1:0]        out_re,
  output logic [W-1:0]        out_im,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [7:0]          drop_cnt
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [N_BINS*W-1:0] buf_re, buf_im;
  logic tick, accept, emit, done, at_last;
  assign frame_ready = state == IDLE && !rst;
  assign accept = frame_valid && frame_ready;
  assign emit = state == WAIT && tick;
  assign done = state == PRESENT && out_ready;
  assign at_last = idx == IDX_W'(N_BINS - 1);
  tick_gen #(.DIV(DIV)) u_tick (
    .fastclk(fastclk),
    .rst(rst),
    .clear(state == IDLE),
    .tick(tick)
  );
  // state register
  always_ff @(posedge fastclk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: capture -> wait for slot -> present until accepted
  always_comb
    state_n = accept ? WAIT : emit ? PRESENT : done ? (at_last ? IDLE : WAIT) : state;
  // frame buffer loaded only on acceptance so later offers cannot corrupt a frame in flight
  always_ff @(posedge fastclk)
    if (accept) begin
      buf_re <= frame_re;
      buf_im <= frame_im;
    end
  // bin index and registered output port; outputs hold between bins and after the frame
  always_ff @(posedge fastclk)
    if (rst) begin
      idx <= '0;
      out_re <= '0;
      out_im <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (accept) idx <= '0;
      if (done && !at_last) idx <= idx + 1'b1;
      if (emit) begin
        out_re <= buf_re[int'(idx)*W +: W];
        out_im <= idx[1:0] == 2'd0 ? '0 : buf_im[int'(idx)*W +: W];
        out_index <= idx;
        out_valid <= 1'b1;
        out_last <= at_last;
      end
      if (done) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  // saturating count of frame offers refused while busy
  always_ff @(posedge fastclk)
    if (rst) drop_cnt <= '0;
    else if (frame_valid && !frame_ready && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
endmodule

// File: tb/tb_fft_out_scheduler.sv
// tb_fft_out_scheduler: randomized and directed scoreboard bench for the FFT output scheduler
module tb_fft_out_scheduler;
  localparam int W = 16;
  localparam int DIV = 4;
  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
  } bin_t;
  logic fastclk = 1'b0;
  logic rst = 1'b1;
  logic [8*W-1:0] frame_re = '0, frame_im = '0;
  logic frame_valid = 1'b0;
  logic frame_ready;
  logic [W-1:0] out_re, out_im;
  logic [2:0] out_index;
  logic out_valid, out_last;
  logic out_ready = 1'b1;
  logic [7:0] drop_cnt;
  int cyc = 0;
  int compared = 0, mismatched = 0;
  bin_t q[$];
  bin_t b;
  bit busy = 0, prev_valid = 0, exp_ready;
  int acc_edge = 0, hs_edge = 0, deadline = 0, last_rise = 0, drop_exp = 0;
  logic [W-1:0] hold_re = '0, hold_im = '0;
  logic [2:0] hold_idx = '0;
  int stall_req = 0, stall_served = 0, stall_left = 0;
  bit rnd_ready = 0;

  fft_out_scheduler #(.W(W), .DIV(DIV)) dut (
    .fastclk(fastclk),
    .rst(rst),
    .frame_re(frame_re),
    .frame_im(frame_im),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .out_re(out_re),
    .out_im(out_im),
    .out_index(out_index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .drop_cnt(drop_cnt)
  );

  always #5 fastclk = ~fastclk;
  // edge counter; at a falling edge it equals the number of rising edges seen so far
  always @(posedge fastclk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8*W-1:0] rnd_frame();
    logic [8*W-1:0] r;
    for (int k = 0; k < 8; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  // consumer: normally ready, optionally random, with one 10-cycle stall on bin 2 per request
  always @(posedge fastclk) begin
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (stall_req != stall_served && out_valid && out_index == 3'd2) begin
      out_ready = 1'b0;
      stall_left = 9;
      stall_served = stall_req;
    end else out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // reference model and monitor: compare what is presented now, then advance the model across the coming edge
  always @(negedge fastclk) begin
    exp_ready = !rst && !busy;
    chk("frame_ready", frame_ready, exp_ready);
    chk("drop_cnt", drop_cnt, drop_exp);
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("out_index", out_index, q[0].idx);
        chk("out_re", out_re, q[0].re);
        chk("out_im", out_im, q[0].im);
        chk("out_last", out_last, q[0].idx == 3'd7);
        if (!prev_valid) begin
          if (q[0].idx == 3'd0) chk("first_latency", cyc - acc_edge, DIV);
          else begin
            chk("gap_in_range", (cyc - hs_edge >= 1) && (cyc - hs_edge <= DIV), 1);
            chk("slot_aligned", (cyc - last_rise) % DIV, 0);
          end
          last_rise = cyc;
        end
      end
    end else begin
      chk("hold_re", out_re, hold_re);
      chk("hold_im", out_im, hold_im);
      chk("hold_index", out_index, hold_idx);
      chk("last_idle", out_last, 0);
      if (busy && cyc >= deadline) begin
        chk("bin_timeout", 0, 1);
        deadline = cyc + 1000000;
      end
    end
    if (rst) begin
      q.delete();
      busy = 0;
      drop_exp = 0;
      hold_re = '0;
      hold_im = '0;
      hold_idx = '0;
      prev_valid = 0;
    end else begin
      if (frame_valid && !exp_ready && drop_exp < 255) drop_exp++;
      if (out_valid && out_ready && q.size() > 0) begin
        b = q.pop_front();
        hold_re = b.re;
        hold_im = b.im;
        hold_idx = b.idx;
        hs_edge = cyc + 1;
        deadline = hs_edge + DIV;
        if (b.idx == 3'd7) busy = 0;
      end
      if (frame_valid && exp_ready) begin
        for (int k = 0; k < 8; k++) begin
          b.re = frame_re[k*W +: W];
          b.im = (k % 4 == 0) ? '0 : frame_im[k*W +: W];
          b.idx = 3'(k);
          q.push_back(b);
        end
        busy = 1;
        acc_edge = cyc + 1;
        deadline = acc_edge + DIV;
      end
      prev_valid = out_valid;
    end
  end

  // offer a frame until it is taken; keep leaves frame_valid asserted afterwards
  task automatic send(input logic [8*W-1:0] re, input logic [8*W-1:0] im, input bit keep);
    int n = 0;
    frame_re = re;
    frame_im = im;
    frame_valid = 1'b1;
    @(negedge fastclk);
    while (!frame_ready) begin
      if (++n > 3000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge fastclk);
    end
    @(posedge fastclk);
    #1;
    if (!keep) frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge fastclk);
    while (!frame_ready) begin
      if (++n > 3000) begin
        chk("idle_timeout", 0, 1);
        break;
      end
      @(negedge fastclk);
    end
    @(posedge fastclk);
    #1;
  endtask

  initial begin
    logic [8*W-1:0] re, im;
    int n;
    repeat (3) @(posedge fastclk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      re[k*W +: W] = W'(16'h0010 + k);
      im[k*W +: W] = W'(16'h0100 + k);
    end
    send(re, im, 0);
    wait_idle();
    stall_req++;
    send(rnd_frame(), rnd_frame(), 0);
    wait_idle();
    for (int f = 0; f < 10; f++) send(rnd_frame(), rnd_frame(), 1);
    frame_valid = 1'b0;
    wait_idle();
    send(rnd_frame(), rnd_frame(), 0);
    n = 0;
    while (!(out_valid && out_index == 3'd5) && n < 500) begin
      @(posedge fastclk);
      #1;
      n++;
    end
    chk("reached_bin5", out_valid && out_index == 3'd5, 1);
    rst = 1'b1;
    @(posedge fastclk);
    #1 rst = 1'b0;
    repeat (3 * DIV) @(posedge fastclk);
    #1;
    rnd_ready = 1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge fastclk);
      #1;
      frame_valid = $urandom_range(0, 2) == 0;
      frame_re = rnd_frame();
      frame_im = rnd_frame();
      rst = $urandom_range(0, 299) == 0;
    end
    frame_valid = 1'b0;
    rst = 1'b0;
    rnd_ready = 0;
    wait_idle();
    repeat (2) @(posedge fastclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fft_out_scheduler.md
FFT_OUT_SCHEDULER -- requirements
Module: fft_out_scheduler

Interface
REQ-001 SHALL have parameter W, default 16: bin component width in bits.
REQ-002 SHALL have parameter DIV, default 25: fastclk cycles per output slot; legal range 2..1023.
REQ-003 SHALL have port fastclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_re  in  8*W  real bins; bin k at [k*W +: W].
REQ-006 SHALL have port frame_im  in  8*W  imaginary bins, same packing; bins 0 and 4 ignored.
REQ-007 SHALL have port frame_valid  in  1  frame offered.
REQ-008 SHALL have port frame_ready  out  1  frame accepted when frame_valid and frame_ready are both high.
REQ-009 SHALL have port out_re, out_im  out  W each  presented bin.
REQ-010 SHALL have port out_index  out  3  bin number of presented bin.
REQ-011 SHALL have port out_valid  out  1; out_ready  in  1; out_last  out  1 (high with bin 7).
REQ-012 SHALL have port drop_cnt  out  8  saturating count of refused frame_valid cycles.

Function
REQ-013 SHALL implement states IDLE, WAIT, PRESENT; frame_ready = (state==IDLE) and not rst, combinational.
REQ-014 IDLE: on frame_valid, SHALL capture both buses into an internal 8-bin buffer, set idx=0, clear divider counter to 0, go to WAIT.
REQ-015 Divider counter SHALL count 0..DIV-1 and wrap; tick is high when counter==DIV-1. The counter SHALL be free-running outside IDLE, and SHALL be held at 0 in IDLE.
REQ-016 WAIT: on tick, SHALL register buffer bin idx onto out_re/out_im/out_index, set out_valid=1, set out_last=(idx==7), go to PRESENT.
REQ-017 out_im SHALL be driven 0 for idx 0 and 4, regardless of frame_im.
REQ-018 PRESENT: outputs SHALL remain stable while out_valid and not out_ready; ticks SHALL be ignored.
REQ-019 PRESENT with out_ready: SHALL clear out_valid and out_last next edge. If idx==7, go to IDLE; else idx+1 and go to WAIT.
REQ-020 First out_valid SHALL rise exactly DIV cycles after the accepting edge when out_ready is held high. Successive bins SHALL then be at most DIV cycles apart and at least 1 cycle apart.
REQ-021 frame_valid high while frame_ready low SHALL increment drop_cnt once per cycle, saturating at 255; the frame is not captured.
REQ-022 The final out_ready handshake (idx 7) coinciding with frame_valid SHALL count as a drop. The next cycle is IDLE, and a still-asserted frame SHALL be accepted then.
REQ-023 out_re/out_im/out_index SHALL hold their last values after the frame completes.
REQ-024 The block SHALL generate no derived clocks; rate control SHALL be by tick enable only.

Reset
REQ-025 rst SHALL force state IDLE, idx 0, divider 0, out_valid 0, out_last 0, out_re/out_im 0, out_index 0, drop_cnt 0. Reset SHALL take priority over all other events.
REQ-026 rst mid-frame SHALL abandon the frame without emitting further bins; frame_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-027 Shared package fft_pkg SHALL hold N_BINS=8, the bin-index width 3, and the state encoding.
REQ-028 Divider SHALL be sub-module tick_gen (ports: fastclk, rst, clear, tick; parameter DIV).

Verification
REQ-029 DIV=4, out_ready=1, frame_re bins 0x0010..0x0017, frame_im bins 0x0100..0x0107 -> eight out_valid pulses 4 cycles apart, the first 4 cycles after acceptance. Expected im values: 0,0x0101,0x0102,0x0103,0,0x0105,0x0106,0x0107; out_last only with index 7.
REQ-030 DIV=4, out_ready low 10 cycles while bin 2 is presented -> bin 2 held stable for 11 cycles, no bin skipped, then bin 3 follows within 4 cycles.
REQ-031 frame_valid held high throughout streaming -> drop_cnt equals the refused cycles, saturating at 255. The second frame is accepted the cycle after the idx-7 handshake.
REQ-032 rst pulsed while bin 5 is presented -> all outputs 0 next cycle, no further bins, frame_ready=1 after release.
REQ-033 DIV=2 back-to-back frames with out_ready=1 -> 16 bins with correct index order 0..7, 0..7, and no buffer corruption from the second capture.
